chenillard_pattern_player: RTL and testbench

Avalon-MM pattern sequencer for the chenillard system: it fetches LED patterns word by word from the on-chip pattern RAM and holds each one on the LED outputs for a programmable number of clock cycles. It sits directly downstream of the 32-bit on-chip memory: its master port reads from that memory's slave port, and its CSR slave is written by the Nios II CPU.

---
 rtl/chenillard_pattern_player.sv | 222 ++++++++++++++++++++++
 tb/tb_chenillard_pattern_player.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chenillard_pattern_player.sv
`default_nettype none
// ============================================================================
// Module   : chenillard_pattern_player
// Purpose  : Avalon-MM LED pattern sequencer. Fetches pattern words from the
//            on-chip pattern RAM one at a time and holds each on the LEDs
//            for a programmable number of clock cycles.
// Ports    : clk, reset_n           - clock, asynchronous active-low reset
//            csr_*                  - CSR slave (CPU side), read latency 1
//            m_*                    - read-only master to the pattern RAM
//            leds                   - current pattern
//            irq                    - level interrupt, DONE & IRQ_EN
// Revision : 1.0 - initial release
// ============================================================================
module chenillard_pattern_player #(
  parameter int ADDR_W = 14,
  parameter int LED_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        csr_address,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  input  logic              csr_read,
  output logic [31:0]       csr_readdata,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  output logic [LED_W-1:0]  leds,
  output logic              irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              run_q, run_d;
  logic              loop_q, loop_d;
  logic              irq_en_q, irq_en_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [31:0]       per_q, per_d;
  logic [ADDR_W-1:0] base_s_q, base_s_d;
  logic [ADDR_W:0]   len_s_q, len_s_d;
  logic [31:0]       per_s_q, per_s_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [LED_W-1:0]  leds_q, leds_d;
  logic              m_read_q, m_read_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic              irq_q, irq_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              w_ctrl_wr;
  logic              w_keep_run;
  logic [ADDR_W:0]   w_next_idx;
  logic [ADDR_W:0]   w_last_idx;
  logic              w_unused_ok;

  assign w_ctrl_wr   = csr_write && (csr_address == 3'd0);
  // RUN value after any CSR write this cycle; clearing it while busy is a
  // software stop, re-asserting it while busy changes nothing.
  assign w_keep_run  = w_ctrl_wr ? csr_writedata[0] : run_q;
  assign w_next_idx  = idx_q + {{ADDR_W{1'b0}}, 1'b1};
  assign w_last_idx  = len_s_q - {{ADDR_W{1'b0}}, 1'b1};
  assign w_unused_ok = ^m_readdata[31:LED_W];

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    loop_d      = loop_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    base_d      = base_q;
    len_d       = len_q;
    per_d       = per_q;
    base_s_d    = base_s_q;
    len_s_d     = len_s_q;
    per_s_d     = per_s_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    leds_d      = leds_q;
    m_address_d = m_address_q;
    rdata_d     = rdata_q;

    // CSR writes; the FSM below may override RUN and DONE (set wins).
    if (csr_write) begin
      case (csr_address)
        3'd0: begin
          run_d    = csr_writedata[0];
          loop_d   = csr_writedata[1];
          irq_en_d = csr_writedata[2];
        end
        3'd1: if (csr_writedata[0]) done_d = 1'b0;
        3'd2: base_d = csr_writedata[ADDR_W-1:0];
        3'd3: len_d  = csr_writedata[ADDR_W:0];
        3'd4: per_d  = csr_writedata;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (w_ctrl_wr && csr_writedata[0]) begin
          base_s_d = base_q;
          len_s_d  = len_q;
          per_s_d  = per_q;
          idx_d    = '0;
          if (len_q == '0) begin
            done_d = 1'b1;
            run_d  = 1'b0;
          end else begin
            state_d     = S_FETCH;
            m_address_d = base_q;
          end
        end
      end
      S_FETCH: begin
        if (!m_waitrequest) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (m_readdatavalid) begin
          leds_d  = m_readdata[LED_W-1:0];
          cnt_d   = (per_s_q == 32'd0) ? 32'd1 : per_s_q;
          state_d = w_keep_run ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        if (!w_keep_run) begin
          state_d = S_IDLE;
        end else if (cnt_q <= 32'd1) begin
          if (idx_q != w_last_idx) begin
            idx_d       = w_next_idx;
            m_address_d = base_s_q + w_next_idx[ADDR_W-1:0];
            state_d     = S_FETCH;
          end else if (loop_q) begin
            idx_d       = '0;
            m_address_d = base_s_q;
            state_d     = S_FETCH;
          end else begin
            done_d  = 1'b1;
            run_d   = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    m_read_d = (state_d == S_FETCH);
    irq_d    = done_q & irq_en_q;

    if (csr_read) begin
      case (csr_address)
        3'd0:    rdata_d = {23'd0, (state_q != S_IDLE), 5'd0, irq_en_q, loop_q, run_q};
        3'd1:    rdata_d = {31'd0, done_q};
        3'd2:    rdata_d = {{(32-ADDR_W){1'b0}}, base_q};
        3'd3:    rdata_d = {{(31-ADDR_W){1'b0}}, len_q};
        3'd4:    rdata_d = per_q;
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      loop_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      per_q       <= '0;
      base_s_q    <= '0;
      len_s_q     <= '0;
      per_s_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      leds_q      <= '0;
      m_read_q    <= 1'b0;
      m_address_q <= '0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      loop_q      <= loop_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      base_q      <= base_d;
      len_q       <= len_d;
      per_q       <= per_d;
      base_s_q    <= base_s_d;
      len_s_q     <= len_s_d;
      per_s_q     <= per_s_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      leds_q      <= leds_d;
      m_read_q    <= m_read_d;
      m_address_q <= m_address_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
    end
  end

  assign csr_readdata = rdata_q;
  assign m_address    = m_address_q;
  assign m_read       = m_read_q;
  assign leds         = leds_q;
  assign irq          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_chenillard_pattern_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_chenillard_pattern_player
// Purpose  : Directed self-checking bench for chenillard_pattern_player with
//            a behavioural on-chip RAM (readdatavalid one cycle after accept).
// Revision : 1.0 - initial release
// ============================================================================
module tb_chenillard_pattern_player;
  localparam int ADDR_W = 14;
  localparam int LED_W  = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [2:0]        csr_address = '0;
  logic              csr_write = 1'b0;
  logic [31:0]       csr_writedata = '0;
  logic              csr_read = 1'b0;
  logic [31:0]       csr_readdata;
  logic [ADDR_W-1:0] m_address;
  logic              m_read;
  logic              m_waitrequest = 1'b0;
  logic [31:0]       m_readdata;
  logic              m_readdatavalid;
  logic [LED_W-1:0]  leds;
  logic              irq;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] ram [0:16383];
  logic [LED_W-1:0] prev_leds = '0;
  logic [LED_W-1:0] chg_val[$];
  int               chg_cyc[$];
  int               acc_addr[$];
  logic             irq_seen = 1'b0;
  logic             mread_seen = 1'b0;

  chenillard_pattern_player #(.ADDR_W(ADDR_W), .LED_W(LED_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_address(csr_address), .csr_write(csr_write), .csr_writedata(csr_writedata),
    .csr_read(csr_read), .csr_readdata(csr_readdata),
    .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .leds(leds), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // On-chip RAM model: data valid the cycle after an accepted read.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_readdatavalid <= 1'b0;
      m_readdata      <= '0;
    end else begin
      m_readdatavalid <= m_read && !m_waitrequest;
      if (m_read && !m_waitrequest) m_readdata <= ram[m_address];
    end
  end

  always @(posedge clk) begin
    if (reset_n && m_read && !m_waitrequest) acc_addr.push_back(int'(m_address));
  end

  always @(posedge clk) begin
    #1;
    if (leds !== prev_leds) begin
      chg_val.push_back(leds);
      chg_cyc.push_back(cyc);
      prev_leds = leds;
    end
    if (irq) irq_seen = 1'b1;
    if (m_read) mread_seen = 1'b1;
  end

  task automatic clear_logs();
    chg_val.delete();
    chg_cyc.delete();
    acc_addr.delete();
    irq_seen   = 1'b0;
    mread_seen = 1'b0;
  endtask

  // Called and returning at a falling edge.
  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(negedge clk);
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    csr_address = a; csr_read = 1'b1;
    @(negedge clk);
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic wait_chg(input int n, input int budget);
    for (int i = 0; i < budget && chg_val.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic [31:0] exp_zero;
    exp_zero = 32'd0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({leds, irq, m_read, m_address, csr_readdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs leds=%h irq=%b m_read=%b m_address=%h rdata=%h, all required 0",
               leds, irq, m_read, m_address, csr_readdata);
    end
    reset_n = 1'b1;
    for (int a = 0; a < 5; a++) begin
      csr_rd(3'(a), r);
      n_vec++;
      if (r !== exp_zero) begin
        n_err++;
        $display("FAIL reset_csr%0d got %h required %h", a, r, exp_zero);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] r;
    logic [7:0]  exp_v [4];
    int t0;
    exp_v = '{8'h01, 8'h02, 8'h04, 8'h08};
    csr_wr(3'd2, 32'h10); csr_wr(3'd3, 32'd4); csr_wr(3'd4, 32'd3);
    clear_logs();
    csr_wr(3'd0, 32'h1);
    t0 = cyc;
    n_vec++;
    if (m_read !== 1'b1 || m_address !== 14'h10) begin
      n_err++;
      $display("FAIL basic_first_read m_read=%b addr=%h required 1 / 0010", m_read, m_address);
    end
    wait_chg(4, 60);
    n_vec++;
    if (chg_val.size() != 4) begin
      n_err++;
      $display("FAIL basic_count got %0d changes required 4", chg_val.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (chg_val[i] !== exp_v[i] || chg_cyc[i] != t0 + 2 + 5 * i) begin
          n_err++;
          $display("FAIL basic_pat%0d got %h@%0d required %h@%0d",
                   i, chg_val[i], chg_cyc[i] - t0, exp_v[i], 2 + 5 * i);
        end
      end
    end
    repeat (8) @(negedge clk);
    n_vec++;
    if (acc_addr.size() != 4 || acc_addr[0] != 'h10 || acc_addr[1] != 'h11 ||
        acc_addr[2] != 'h12 || acc_addr[3] != 'h13) begin
      n_err++;
      $display("FAIL basic_addrs got %0d reads required 4 at 0x10..0x13", acc_addr.size());
    end
    csr_rd(3'd1, r);
    n_vec++;
    if (r !== 32'd1) begin n_err++; $display("FAIL basic_done got %h required 1", r); end
    csr_rd(3'd0, r);
    n_vec++;
    if (r !== 32'd0) begin n_err++; $display("FAIL basic_ctrl got %h required 0", r); end
    n_vec++;
    if (leds !== 8'h08 || m_read !== 1'b0) begin
      n_err++;
      $display("FAIL basic_idle leds=%h m_read=%b required 08 / 0", leds, m_read);
    end
  endtask

  task automatic test_loop_irq();
    logic [31:0] r;
    logic [7:0]  exp_v [5];
    int t0;
    exp_v = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01};
    csr_wr(3'd1, 32'h1);
    repeat (2) @(negedge clk);
    clear_logs();
    csr_wr(3'd0, 32'h7);
    t0 = cyc;
    wait_chg(5, 80);
    n_vec++;
    if (chg_val.size() != 5) begin
      n_err++;
      $display("FAIL loop_count got %0d changes required 5", chg_val.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_vec++;
        if (chg_val[i] !== exp_v[i] || chg_cyc[i] != t0 + 2 + 5 * i) begin
          n_err++;
          $display("FAIL loop_pat%0d got %h@%0d required %h@%0d",
                   i, chg_val[i], chg_cyc[i] - t0, exp_v[i], 2 + 5 * i);
        end
      end
    end
    // Now in HOLD of the wrapped first pattern: software stop.
    csr_wr(3'd0, 32'h6);
    csr_rd(3'd0, r);
    n_vec++;
    if (r !== 32'h6) begin n_err++; $display("FAIL loop_stop_ctrl got %h required 00000006", r); end
    csr_rd(3'd1, r);
    n_vec++;
    if (r !== 32'd0) begin n_err++; $display("FAIL loop_stop_done got %h required 0", r); end
    repeat (6) @(negedge clk);
    n_vec++;
    if (irq_seen !== 1'b0 || acc_addr.size() != 5 || leds !== 8'h01) begin
      n_err++;
      $display("FAIL loop_quiet irq_seen=%b reads=%0d leds=%h required 0 / 5 / 01",
               irq_seen, acc_addr.size(), leds);
    end
  endtask

  task automatic test_wrap_period0();
    logic [31:0] r;
    int t0;
    csr_wr(3'd2, 32'h3FFF); csr_wr(3'd3, 32'd2); csr_wr(3'd4, 32'd0);
    clear_logs();
    csr_wr(3'd0, 32'h1);
    t0 = cyc;
    wait_chg(2, 30);
    n_vec++;
    if (chg_val.size() != 2 || chg_val[0] !== 8'hA5 || chg_val[1] !== 8'h5A ||
        chg_cyc[0] != t0 + 2 || chg_cyc[1] != t0 + 5) begin
      n_err++;
      $display("FAIL wrap_pats got %0d changes, required A5@2 5A@5", chg_val.size());
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (acc_addr.size() != 2 || acc_addr[0] != 'h3FFF || acc_addr[1] != 0) begin
      n_err++;
      $display("FAIL wrap_addrs got %0d reads required 3FFF then 0000", acc_addr.size());
    end
    csr_rd(3'd1, r);
    n_vec++;
    if (r !== 32'd1) begin n_err++; $display("FAIL wrap_done got %h required 1", r); end
  endtask

  task automatic test_waitreq_stop();
    logic [31:0] r;
    int t0;
    csr_wr(3'd1, 32'h1);
    csr_wr(3'd2, 32'h10); csr_wr(3'd3, 32'd4); csr_wr(3'd4, 32'd3);
    m_waitrequest = 1'b1;
    clear_logs();
    csr_wr(3'd0, 32'h1);
    t0 = cyc;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (m_read !== 1'b1 || m_address !== 14'h10) begin
        n_err++;
        $display("FAIL stall_hold%0d m_read=%b addr=%h required 1 / 0010", i, m_read, m_address);
      end
      @(negedge clk);
    end
    csr_wr(3'd0, 32'h0);
    n_vec++;
    if (m_read !== 1'b1 || m_address !== 14'h10) begin
      n_err++;
      $display("FAIL stall_after_stop m_read=%b addr=%h required 1 / 0010", m_read, m_address);
    end
    @(negedge clk);
    m_waitrequest = 1'b0;
    wait_chg(1, 20);
    repeat (4) @(negedge clk);
    n_vec++;
    if (chg_val.size() != 1 || chg_val[0] !== 8'h01 || chg_cyc[0] != t0 + 6) begin
      n_err++;
      $display("FAIL stall_leds got %0d changes, required one change to 01 at +6", chg_val.size());
    end
    n_vec++;
    if (acc_addr.size() != 1 || m_read !== 1'b0) begin
      n_err++;
      $display("FAIL stall_reads got %0d reads m_read=%b required 1 / 0", acc_addr.size(), m_read);
    end
    csr_rd(3'd0, r);
    n_vec++;
    if (r !== 32'd0) begin n_err++; $display("FAIL stall_ctrl got %h required 0", r); end
    csr_rd(3'd1, r);
    n_vec++;
    if (r !== 32'd0) begin n_err++; $display("FAIL stall_done got %h required 0", r); end
  endtask

  task automatic test_len0_irq();
    logic [31:0] r;
    csr_wr(3'd3, 32'd0);
    clear_logs();
    csr_wr(3'd0, 32'h5);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL len0_irq_lag irq=%b required 0", irq); end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL len0_irq irq=%b required 1", irq); end
    csr_rd(3'd1, r);
    n_vec++;
    if (r !== 32'd1) begin n_err++; $display("FAIL len0_done got %h required 1", r); end
    csr_rd(3'd0, r);
    n_vec++;
    if (r !== 32'h4) begin n_err++; $display("FAIL len0_ctrl got %h required 00000004", r); end
    n_vec++;
    if (mread_seen !== 1'b0 || acc_addr.size() != 0) begin
      n_err++;
      $display("FAIL len0_noread m_read_seen=%b reads=%0d required 0 / 0", mread_seen, acc_addr.size());
    end
    csr_wr(3'd1, 32'h1);
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL len0_irq_clear irq=%b required 0", irq); end
  endtask

  task automatic test_done_set_wins();
    logic [31:0] r;
    csr_wr(3'd2, 32'h12); csr_wr(3'd3, 32'd1); csr_wr(3'd4, 32'd1);
    csr_wr(3'd0, 32'h1);
    repeat (2) @(negedge clk);
    n_vec++;
    if (leds !== 8'h04) begin n_err++; $display("FAIL setwins_leds got %h required 04", leds); end
    csr_wr(3'd1, 32'h1);  // same edge as the HOLD expiry
    csr_rd(3'd1, r);
    n_vec++;
    if (r !== 32'd1) begin n_err++; $display("FAIL setwins_done got %h required 1", r); end
    csr_wr(3'd1, 32'h1);
    csr_rd(3'd1, r);
    n_vec++;
    if (r !== 32'd0) begin n_err++; $display("FAIL w1c_done got %h required 0", r); end
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    csr_wr(3'd2, 32'h10); csr_wr(3'd3, 32'd4); csr_wr(3'd4, 32'd10);
    csr_rd(3'd4, r);
    n_vec++;
    if (r !== 32'd10) begin n_err++; $display("FAIL period_rd got %h required 0000000a", r); end
    clear_logs();
    csr_wr(3'd0, 32'h3);
    wait_chg(1, 20);
    @(negedge clk);
    csr_rd(3'd0, r);
    n_vec++;
    if (r !== 32'h103) begin n_err++; $display("FAIL busy_rd got %h required 00000103", r); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({leds, irq, m_read, m_address, csr_readdata} !== '0) begin
      n_err++;
      $display("FAIL async_reset leds=%h irq=%b m_read=%b m_address=%h rdata=%h, all required 0",
               leds, irq, m_read, m_address, csr_readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    csr_rd(3'd2, r);
    n_vec++;
    if (r !== 32'd0) begin n_err++; $display("FAIL post_reset_base got %h required 0", r); end
    csr_wr(3'd5, 32'hFFFF_FFFF);
    csr_rd(3'd5, r);
    n_vec++;
    if (r !== 32'd0) begin n_err++; $display("FAIL unmapped_rd got %h required 0", r); end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 32'd0;
    ram[16'h10]   = 32'hDEAD_BE01;
    ram[16'h11]   = 32'hDEAD_BE02;
    ram[16'h12]   = 32'hDEAD_BE04;
    ram[16'h13]   = 32'hDEAD_BE08;
    ram[16'h3FFF] = 32'h0000_00A5;
    ram[16'h0]    = 32'h0000_005A;
    test_reset();
    test_basic();
    test_loop_irq();
    test_wrap_period0();
    test_waitreq_stop();
    test_len0_irq();
    test_done_set_wins();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
